clk_div_multi: RTL
==================

// Module: clk_div_multi
// PURPOSE
//  Multi-channel integer clock divider, successor to the single-channel divider.
//  Derives NUM_CH divided clocks from i_ref_clk; each channel has its own enable and ratio.
//  Ratio and enable changes are taken only at a period boundary, so no runt pulses occur
//  on reconfiguration. Sits in the clock-control block; feeds UART/peripheral clock domains.
// PARAMETERS
//  NUM_CH       2  number of independent divider channels
//  RATIO_WIDTH  8  width of each channel's ratio; legal divide range 2..2^RATIO_WIDTH-1
// PORTS
//  i_ref_clk      in   1                    reference clock (sole clock)
//  i_rst_n        in   1                    asynchronous active-low reset
//  i_clk_en       in   NUM_CH               per-channel divide enable
//  i_div_ratio    in   NUM_CH*RATIO_WIDTH   packed ratios, channel k at [k*RATIO_WIDTH +: RATIO_WIDTH]
//  o_div_clk      out  NUM_CH               divided (or bypassed) clock per channel
//  o_ratio_ack    out  NUM_CH               1-cycle pulse: channel loaded a new active ratio
//  o_div_tick     out  NUM_CH               only with CLKDIV_TICK_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Per channel: state IDLE/HIGH/LOW; registers div_q, bypass_q, cnt[RATIO_WIDTH-1:0], ratio_q.
//  - o_div_clk[k] = bypass_q ? i_ref_clk : div_q. bypass_q changes only at a boundary with div_q=0.
//  - Active ratio R=ratio_q: H = R - (R>>1) high cycles, L = R>>1 low cycles; period = R cycles.
//    Even R: 50% duty. Odd R: high phase one cycle longer.
//  - "Valid request" = i_clk_en[k] && i_div_ratio[k] >= 2.
//  - Reset (async, any time): state IDLE, bypass_q=1, div_q=0, cnt=0, ratio_q=0, acks/ticks 0.
//    o_div_clk follows i_ref_clk during and after reset until a valid request.
//  - IDLE: on a valid request -> HIGH, ratio_q<=request, div_q<=1, bypass_q<=0, cnt<=1,
//    ack pulse. First divided rising edge is 1 ref cycle after the request is sampled.
//  - HIGH: cnt==H -> LOW, div_q<=0, cnt<=1; else cnt++.
//  - LOW: cnt==L is the period boundary; else cnt++. At the boundary, sample inputs:
//      valid request  -> HIGH, div_q<=1, cnt<=1; ratio_q<=request; ack only if request != ratio_q.
//      otherwise      -> IDLE, bypass_q<=1, div_q<=0 (output reverts to i_ref_clk).
//  - Ratio or enable changes mid-period are ignored until the boundary; the period in
//    flight always completes with the old ratio. Ratio 0/1 with enable high = bypass.
//  - No combinational path from i_div_ratio/i_clk_en to o_div_clk; channels are independent.
// CONFIGURATION
//  - CLKDIV_TICK_EN defined: o_div_tick[k] pulses high for exactly one i_ref_clk cycle in the
//    cycle div_q rises (IDLE->HIGH or LOW->HIGH); held 0 in bypass.
//  - Not defined: port o_div_tick absent, no tick logic.
// STRUCTURE
//  - Package clk_div_pkg: state enum {IDLE, HIGH, LOW}, RATIO_MIN=2 constant.
//  - Sub-module clk_div_ch (one channel, RATIO_WIDTH param); top is a generate loop over NUM_CH.
// TESTING
//  - Reset: i_rst_n=0 mid-HIGH on ch0 -> o_div_clk[0] tracks i_ref_clk, ack=0, same cycle.
//  - Even: ch0 en=1 ratio=4 -> period 4, high 2/low 2; single ack pulse at start.
//  - Odd: ch1 ratio=5 -> high 3/low 2; ratio=255 (W=8) -> high 128/low 127, no counter wrap.
//  - Reconfig: ratio 4->6 mid-HIGH -> current 4-cycle period completes, then 6; one ack at boundary.
//  - Disable: en 1->0 mid-period -> period completes, then bypass; ratio=1 with en=1 -> bypass, no ack.
//  - Independence + macro: ch0=3, ch1=2 run concurrently; with CLKDIV_TICK_EN one tick per rising div edge.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ch_state_e;

  localparam int RATIO_MIN = 2;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: glitch-free ratio/enable changes at period boundaries only.
// With CLKDIV_TICK_EN defined, adds a one-cycle tick on every divided rising edge.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int RATIO_WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   en_i,
  input  logic [RATIO_WIDTH-1:0] ratio_i,
  output logic                   div_clk_o,
  output logic                   ack_o
`ifdef CLKDIV_TICK_EN
  ,
  output logic                   tick_o
`endif
);

  localparam logic [RATIO_WIDTH-1:0] RatioMin = RATIO_WIDTH'(RATIO_MIN);
  localparam logic [RATIO_WIDTH-1:0] CntOne   = RATIO_WIDTH'(1);

  ch_state_e              state_q, state_d;
  logic                   div_q, div_d;
  logic                   bypass_q, bypass_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
  logic                   ack_q, ack_d;
  logic                   tick_q, tick_d;

  logic                   validReq;
  logic [RATIO_WIDTH-1:0] highLen;
  logic [RATIO_WIDTH-1:0] lowLen;

  assign validReq = en_i && (ratio_i >= RatioMin);
  // Odd ratios give the extra cycle to the high phase
  assign highLen  = ratio_q - (ratio_q >> 1);
  assign lowLen   = ratio_q >> 1;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bypass_d = bypass_q;
    cnt_d    = cnt_q;
    ratio_d  = ratio_q;
    ack_d    = 1'b0;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (validReq) begin
          state_d  = HIGH;
          ratio_d  = ratio_i;
          div_d    = 1'b1;
          bypass_d = 1'b0;
          cnt_d    = CntOne;
          ack_d    = 1'b1;
          tick_d   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == highLen) begin
          state_d = LOW;
          div_d   = 1'b0;
          cnt_d   = CntOne;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      LOW: begin
        // Inputs are only looked at here, at the end of a full period
        if (cnt_q == lowLen) begin
          if (validReq) begin
            state_d = HIGH;
            div_d   = 1'b1;
            cnt_d   = CntOne;
            ratio_d = ratio_i;
            ack_d   = (ratio_i != ratio_q);
            tick_d  = 1'b1;
          end else begin
            state_d  = IDLE;
            bypass_d = 1'b1;
            div_d    = 1'b0;
            cnt_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d  = IDLE;
        bypass_d = 1'b1;
        div_d    = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      div_q    <= 1'b0;
      bypass_q <= 1'b1;
      cnt_q    <= '0;
      ratio_q  <= '0;
      ack_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bypass_q <= bypass_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      ack_q    <= ack_d;
      tick_q   <= tick_d;
    end
  end

  assign div_clk_o = bypass_q ? clk_i : div_q;
  assign ack_o     = ack_q;

`ifdef CLKDIV_TICK_EN
  assign tick_o = tick_q;
`else
  logic unusedTick;
  assign unusedTick = tick_q;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH independent integer clock dividers from one reference clock.
// Optional per-channel rising-edge tick output when CLKDIV_TICK_EN is defined.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int RATIO_WIDTH = 8
) (
  input  logic                          i_ref_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_CH-1:0]             i_clk_en,
  input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]             o_div_clk,
  output logic [NUM_CH-1:0]             o_ratio_ack
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]             o_div_tick
`endif
);

  for (genvar k = 0; k < NUM_CH; k++) begin : gCh
    clk_div_ch #(
      .RATIO_WIDTH(RATIO_WIDTH)
    ) uCh (
      .clk_i    (i_ref_clk),
      .rst_ni   (i_rst_n),
      .en_i     (i_clk_en[k]),
      .ratio_i  (i_div_ratio[k*RATIO_WIDTH +: RATIO_WIDTH]),
      .div_clk_o(o_div_clk[k]),
      .ack_o    (o_ratio_ack[k])
`ifdef CLKDIV_TICK_EN
      ,
      .tick_o   (o_div_tick[k])
`endif
    );
  end

endmodule
